// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 register numbers, exception codes, WB-to-CP0 bus layout and
// read-format structs used by the coprocessor-0 block.
package cp0_ctrl_pkg;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;
  localparam logic [4:0] CR_PRID     = 5'd15;
  localparam logic [4:0] CR_CONFIG   = 5'd16;

  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;

  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        bd;
    logic [31:0] pc;
  } wb_bus_t;

  localparam int WB_CP0_BUS_W = $bits(wb_bus_t);

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_ERET,
    EV_MTC0
  } cp0_ev_e;

  typedef struct packed {
    logic [8:0] zero_hi;
    logic       bev;
    logic [5:0] zero_mid;
    logic [7:0] im;
    logic [5:0] zero_lo;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] zero_hi;
    logic [7:0]  ip;
    logic        zero_mid;
    logic [4:0]  excode;
    logic [1:0]  zero_lo;
  } cause_t;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EX_ADEL) || (code == EX_ADES);
  endfunction

endpackage

// File: rtl/cp0_ctrl_int_sync.sv
// Single-bit synchronizer: STAGES flops in series, async active-low reset.
// Output follows the input STAGES rising edges later.
module cp0_int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) chain <= '0;
        else         chain <= d;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) chain <= '0;
        else         chain <= {chain[STAGES-2:0], d};
      end
    end
  endgenerate

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: exception/ERET/MTC0 state updates at the clock edge, combinational
// MFC0 read port, Count/Compare timer and synchronised interrupt request; never stalls.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int          EXT_INT_W   = 6,
  parameter int          SYNC_STAGES = 2,
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] PRID_VAL    = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL  = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [EXT_INT_W-1:0] ext_int,
  input  logic                 wb_ex,
  input  logic [4:0]           wb_excode,
  input  logic [31:0]          wb_badvaddr,
  input  logic                 wb_bd,
  input  logic [31:0]          wb_pc,
  input  logic                 eret_flush,
  input  logic                 mtc0_we,
  input  logic [4:0]           c0_waddr,
  input  logic [2:0]           c0_wsel,
  input  logic [31:0]          c0_wdata,
  input  logic [4:0]           c0_raddr,
  input  logic [2:0]           c0_rsel,
  output logic [31:0]          c0_rdata,
  output logic [31:0]          epc,
  output logic                 has_int
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

  wb_bus_t wb;
  assign wb = {wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc};

  // ---------------------------------------------------------------------------
  // External interrupt synchronisers, padded to the six hardware IP lines
  // ---------------------------------------------------------------------------
  logic [EXT_INT_W-1:0] ext_sync;
  logic [5:0]           ext_pad;

  generate
    for (genvar i = 0; i < EXT_INT_W; i++) begin : g_sync
      cp0_int_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ext_int[i]),
        .q      (ext_sync[i])
      );
    end
  endgenerate

  always_comb begin
    ext_pad = '0;
    ext_pad[EXT_INT_W-1:0] = ext_sync;
  end

  // ---------------------------------------------------------------------------
  // Event arbitration: exception beats ERET beats MTC0
  // ---------------------------------------------------------------------------
  cp0_ev_e ev;

  always_comb begin
    ev = EV_NONE;
    if (wb.ex)           ev = EV_EXC;
    else if (eret_flush) ev = EV_ERET;
    else if (mtc0_we)    ev = EV_MTC0;
  end

  logic wr_sel0, wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_sel0    = (ev == EV_MTC0) && (c0_wsel == 3'd0);
  assign wr_count   = wr_sel0 && (c0_waddr == CR_COUNT);
  assign wr_compare = wr_sel0 && (c0_waddr == CR_COMPARE);
  assign wr_status  = wr_sel0 && (c0_waddr == CR_STATUS);
  assign wr_cause   = wr_sel0 && (c0_waddr == CR_CAUSE);
  assign wr_epc     = wr_sel0 && (c0_waddr == CR_EPC);

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [31:0]      badvaddr_q, count_q, compare_q, epc_q;
  logic [7:0]       im_q;
  logic             exl_q, ie_q;
  logic             bd_q, ti_q, ti_arm_q;
  logic [5:0]       ip_hw_q;
  logic [1:0]       ip_sw_q;
  logic [4:0]       excode_q;
  logic [DIV_W-1:0] div_q;

  logic        div_last, count_inc;
  logic [31:0] count_plus1;

  assign div_last    = (div_q == DIV_MAX);
  assign count_inc   = div_last && !wr_count;
  assign count_plus1 = count_q + 32'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= '0;
      count_q <= '0;
    end else if (wr_count) begin
      div_q   <= '0;
      count_q <= c0_wdata;
    end else if (div_last) begin
      div_q   <= '0;
      count_q <= count_plus1;
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  // A match is armed at the increment edge and lands in TI on the next edge,
  // so directly loaded or reset values can never raise the timer interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare_q <= '0;
      ti_arm_q  <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      ti_arm_q <= count_inc && (count_plus1 == compare_q) && !wr_compare;
      if (wr_compare) begin
        compare_q <= c0_wdata;
        ti_q      <= 1'b0;
      end else if (ti_arm_q) begin
        ti_q      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      im_q  <= '0;
    end else begin
      case (ev)
        EV_EXC:  exl_q <= 1'b1;
        EV_ERET: exl_q <= 1'b0;
        default: begin
          if (wr_status) begin
            im_q  <= c0_wdata[15:8];
            exl_q <= c0_wdata[1];
            ie_q  <= c0_wdata[0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bd_q       <= 1'b0;
      excode_q   <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      ip_hw_q <= ext_pad;
      if (ev == EV_EXC) begin
        excode_q <= wb.excode;
        if (!exl_q) begin
          bd_q  <= wb.bd;
          epc_q <= wb.bd ? (wb.pc - 32'd4) : wb.pc;
        end
        if (is_addr_exc(wb.excode)) badvaddr_q <= wb.badvaddr;
      end else begin
        if (wr_epc)   epc_q   <= c0_wdata;
        if (wr_cause) ip_sw_q <= c0_wdata[9:8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read formatting and outputs
  // ---------------------------------------------------------------------------
  logic [7:0] ip;
  status_t    status_rd;
  cause_t     cause_rd;

  // Unused hardware lines are zero in ext_pad, so IP7 reduces to TI when EXT_INT_W < 6.
  assign ip = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

  always_comb begin
    status_rd     = '0;
    status_rd.bev = 1'b1;
    status_rd.im  = im_q;
    status_rd.exl = exl_q;
    status_rd.ie  = ie_q;

    cause_rd        = '0;
    cause_rd.bd     = bd_q;
    cause_rd.ti     = ti_q;
    cause_rd.ip     = ip;
    cause_rd.excode = excode_q;
  end

  always_comb begin
    c0_rdata = '0;
    if (c0_rsel == 3'd0) begin
      case (c0_raddr)
        CR_BADVADDR: c0_rdata = badvaddr_q;
        CR_COUNT:    c0_rdata = count_q;
        CR_COMPARE:  c0_rdata = compare_q;
        CR_STATUS:   c0_rdata = status_rd;
        CR_CAUSE:    c0_rdata = cause_rd;
        CR_EPC:      c0_rdata = epc_q;
        CR_PRID:     c0_rdata = PRID_VAL;
        CR_CONFIG:   c0_rdata = CONFIG_VAL;
        default:     c0_rdata = '0;
      endcase
    end
  end

  assign epc     = epc_q;
  assign has_int = (|(ip & im_q)) && ie_q && !exl_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: stimulus queues expected read/epc/has_int values,
// a monitor pops and compares each time a read strobe is presented.
module tb_cp0_ctrl;

  localparam int          EXT_INT_W   = 6;
  localparam int          SYNC_STAGES = 2;
  localparam int          COUNT_DIV   = 2;
  localparam logic [31:0] PRID_VAL    = 32'h0000_4220;
  localparam logic [31:0] CONFIG_VAL  = 32'h8000_0000;

  localparam int K_RD  = 0;
  localparam int K_INT = 1;
  localparam int K_EPC = 2;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [EXT_INT_W-1:0] ext_int;
  logic                 wb_ex;
  logic [4:0]           wb_excode;
  logic [31:0]          wb_badvaddr;
  logic                 wb_bd;
  logic [31:0]          wb_pc;
  logic                 eret_flush;
  logic                 mtc0_we;
  logic [4:0]           c0_waddr;
  logic [2:0]           c0_wsel;
  logic [31:0]          c0_wdata;
  logic [4:0]           c0_raddr;
  logic [2:0]           c0_rsel;
  logic [31:0]          c0_rdata;
  logic [31:0]          epc;
  logic                 has_int;

  cp0_ctrl #(
    .EXT_INT_W   (EXT_INT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .COUNT_DIV   (COUNT_DIV),
    .PRID_VAL    (PRID_VAL),
    .CONFIG_VAL  (CONFIG_VAL)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ext_int     (ext_int),
    .wb_ex       (wb_ex),
    .wb_excode   (wb_excode),
    .wb_badvaddr (wb_badvaddr),
    .wb_bd       (wb_bd),
    .wb_pc       (wb_pc),
    .eret_flush  (eret_flush),
    .mtc0_we     (mtc0_we),
    .c0_waddr    (c0_waddr),
    .c0_wsel     (c0_wsel),
    .c0_wdata    (c0_wdata),
    .c0_raddr    (c0_raddr),
    .c0_rsel     (c0_rsel),
    .c0_rdata    (c0_rdata),
    .epc         (epc),
    .has_int     (has_int)
  );

  always #10 clk = ~clk;

  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        rd_vld  = 1'b0;

  int          mon_kind;
  logic [31:0] mon_exp;
  logic [31:0] mon_act;
  string       mon_name;

  always @(posedge rd_vld) begin
    n_tests++;
    if (q_exp.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow: strobe with no expected entry");
    end else begin
      mon_kind = q_kind.pop_front();
      mon_exp  = q_exp.pop_front();
      mon_name = q_name.pop_front();
      case (mon_kind)
        K_RD:    mon_act = c0_rdata;
        K_INT:   mon_act = {31'b0, has_int};
        default: mon_act = epc;
      endcase
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: got %08h expected %08h", mon_name, mon_act, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [4:0] a, input logic [2:0] s,
                     input logic [31:0] exp, input string nm);
    c0_raddr = a;
    c0_rsel  = s;
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(nm);
    #1 rd_vld = 1'b1;
    #1 rd_vld = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    chk(K_RD, a, 3'd0, exp, nm);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    mtc0_we  = 1'b1;
    c0_waddr = a;
    c0_wsel  = s;
    c0_wdata = d;
    tick();
    mtc0_we  = 1'b0;
  endtask

  task automatic raise_ex(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                          input logic [31:0] bva);
    wb_ex       = 1'b1;
    wb_excode   = code;
    wb_bd       = bd;
    wb_pc       = pc;
    wb_badvaddr = bva;
    tick();
    wb_ex       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; ext_int = '0; wb_ex = 1'b0; wb_excode = '0; wb_badvaddr = '0;
    wb_bd = 1'b0; wb_pc = '0; eret_flush = 1'b0; mtc0_we = 1'b0; c0_waddr = '0;
    c0_wsel = '0; c0_wdata = '0; c0_raddr = '0; c0_rsel = '0;

    // Reset state
    #1;
    chk(K_RD, 5'd0, 3'd0, 32'h0, "reset_rdata_reg0");
    chk(K_EPC, 5'd0, 3'd0, 32'h0, "reset_epc");
    chk(K_INT, 5'd0, 3'd0, 32'h0, "reset_has_int");
    rd(5'd12, 32'h0040_0000, "reset_status");
    tick();
    resetn = 1'b1;
    tick();
    rd(5'd9, 32'h0, "count_before_first_inc");
    tick();
    rd(5'd9, 32'h1, "count_first_inc");

    // Status write and external interrupt latency
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    rd(5'd12, 32'h0040_FF01, "status_write");
    chk(K_INT, 5'd0, 3'd0, 32'h0, "has_int_idle");
    ext_int[0] = 1'b1;
    for (int i = 0; i < SYNC_STAGES; i++) tick();
    chk(K_INT, 5'd0, 3'd0, 32'h0, "has_int_early");
    tick();
    chk(K_INT, 5'd0, 3'd0, 32'h1, "has_int_ext0");
    rd(5'd13, 32'h0000_0400, "cause_ip2");
    ext_int[0] = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1; i++) tick();
    chk(K_INT, 5'd0, 3'd0, 32'h0, "has_int_ext0_clear");
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0000_0300, "cause_sw_ip");
    chk(K_INT, 5'd0, 3'd0, 32'h1, "has_int_sw_ip");
    mtc0(5'd13, 3'd0, 32'h0);

    // Count / Compare / TI
    mtc0(5'd11, 3'd0, 32'd5);
    mtc0(5'd9, 3'd0, 32'd3);
    rd(5'd9, 32'd3, "count_load");
    for (int i = 0; i < 4; i++) tick();
    rd(5'd9, 32'd5, "count_reach_cmp");
    rd(5'd13, 32'h0000_0000, "ti_not_yet");
    tick();
    rd(5'd13, 32'h4000_8000, "ti_set");
    chk(K_INT, 5'd0, 3'd0, 32'h1, "has_int_timer");
    mtc0(5'd11, 3'd0, 32'd9);
    rd(5'd13, 32'h0000_0000, "ti_cleared_by_compare");

    // Wrap does not fire TI
    mtc0(5'd11, 3'd0, 32'd5);
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < COUNT_DIV; i++) tick();
    rd(5'd9, 32'h0, "count_wrap");
    tick();
    rd(5'd13, 32'h0, "ti_after_wrap");
    mtc0(5'd11, 3'd0, 32'hFFFF_0000);

    // Exceptions
    raise_ex(5'h05, 1'b1, 32'hBFC0_0104, 32'h1234_5679);
    rd(5'd14, 32'hBFC0_0100, "epc_delay_slot");
    chk(K_EPC, 5'd0, 3'd0, 32'hBFC0_0100, "epc_port");
    rd(5'd13, 32'h8000_0014, "cause_ades_bd");
    rd(5'd8, 32'h1234_5679, "badvaddr_ades");
    rd(5'd12, 32'h0040_FF03, "status_exl_set");
    chk(K_INT, 5'd0, 3'd0, 32'h0, "has_int_masked_exl");
    tick();
    raise_ex(5'h04, 1'b0, 32'h8000_0000, 32'hAAAA_0000);
    rd(5'd14, 32'hBFC0_0100, "epc_hold_nested");
    rd(5'd13, 32'h8000_0010, "cause_nested_bd_hold");
    rd(5'd8, 32'hAAAA_0000, "badvaddr_adel");
    tick();

    // ERET beats a same-cycle MTC0
    eret_flush = 1'b1;
    mtc0(5'd12, 3'd0, 32'h0);
    eret_flush = 1'b0;
    rd(5'd12, 32'h0040_FF01, "eret_clears_exl_drops_mtc0");

    // Exception beats a same-cycle MTC0 to EPC
    mtc0_we = 1'b1; c0_waddr = 5'd14; c0_wsel = 3'd0; c0_wdata = 32'hDEAD_BEEF;
    raise_ex(5'h00, 1'b0, 32'h8000_0180, 32'h0);
    mtc0_we = 1'b0;
    chk(K_EPC, 5'd0, 3'd0, 32'h8000_0180, "epc_ex_over_mtc0");
    rd(5'd13, 32'h0000_0000, "cause_int_code");
    rd(5'd8, 32'hAAAA_0000, "badvaddr_hold_non_addr");
    eret_flush = 1'b1;
    tick();
    eret_flush = 1'b0;
    rd(5'd12, 32'h0040_FF01, "eret_exl_clear");
    mtc0(5'd14, 3'd0, 32'h0000_1234);
    chk(K_EPC, 5'd0, 3'd0, 32'h0000_1234, "epc_mtc0");

    // Constants, sel field, unimplemented registers
    rd(5'd15, PRID_VAL, "prid");
    rd(5'd16, CONFIG_VAL, "config");
    chk(K_RD, 5'd12, 3'd1, 32'h0, "status_sel1");
    mtc0(5'd12, 3'd1, 32'h0);
    rd(5'd12, 32'h0040_FF01, "status_sel1_write_ignored");
    mtc0(5'd3, 3'd0, 32'hFFFF_FFFF);
    rd(5'd3, 32'h0, "unimpl_reg");

    // Asynchronous reset mid-operation
    resetn = 1'b0;
    #1;
    rd(5'd12, 32'h0040_0000, "midreset_status");
    chk(K_EPC, 5'd0, 3'd0, 32'h0, "midreset_epc");
    rd(5'd8, 32'h0, "midreset_badvaddr");
    tick();
    resetn = 1'b1;
    tick();

    #5;
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
